// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: op encodings, exception codes, FSM states.
// Imported by the MEM stage, its load aligner and the writeback stage.
package mem_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    localparam logic [7:0] EXC_NONE   = 8'h00;
    localparam logic [7:0] EXC_ADEL   = 8'h04;
    localparam logic [7:0] EXC_ADES   = 8'h05;
    localparam logic [7:0] EXC_BUS    = 8'h07;
    localparam logic [7:0] TRAP_STALL = 8'hFF;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic misaligned(input logic [3:0] op,
                                        input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return a != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Word-wide data-memory bus with req/ack handshake.
// master drives the request side, slave returns ack/err/rdata.
interface mem_stage_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, err, rdata
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data extraction: picks the byte/halfword lane from a bus word
// and sign- or zero-extends it to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        b       = shifted[7:0];
        h       = addr[1] ? rdata[31:16] : rdata[15:0];
        data    = rdata;
        case (op)
            OP_LB:   data = {{24{b[7]}}, b};
            OP_LBU:  data = {24'h0, b};
            OP_LH:   data = {{16{h[15]}}, h};
            OP_LHU:  data = {16'h0, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: loads/stores over a req/ack bus, alignment traps.
// Optional bus-wait timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_result,
    input  logic [31:0] in_store_data,
    input  logic        in_wen,
    input  logic [4:0]  in_windex,
    input  logic [7:0]  exception_in,
    output logic        stall,
    mem_stage_if.master dmem,
    output logic        wb_wen,
    output logic [4:0]  wb_windex,
    output logic [31:0] wb_wdata,
    output logic [7:0]  wb_exception
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be positive");
    end

    state_e      state, state_n;
    logic [3:0]  op_q;
    logic [1:0]  lane_q;
    logic [4:0]  widx_q;
    logic        ld, st, mis, start, tmo;
    logic [3:0]  st_be;
    logic [31:0] st_wd;
    logic [31:0] ld_data;

    assign ld    = is_load(in_op);
    assign st    = is_store(in_op);
    assign mis   = misaligned(in_op, in_result[1:0]);
    assign start = (state == S_IDLE) && in_valid
                   && (exception_in == EXC_NONE)
                   && (ld || st) && !mis;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt <= '0;
        end else if (state == S_ACCESS && !dmem.ack) begin
            cnt <= cnt + CW'(1);
        end
    end

    // fires on the last allowed wait cycle so stall drops with it
    assign tmo = (state == S_ACCESS) && !dmem.ack
                 && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_ACCESS;
            S_ACCESS: if (dmem.ack || tmo) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (state)
            S_IDLE:   stall = start;
            S_ACCESS: stall = !(dmem.ack || tmo);
            default:  stall = 1'b0;
        endcase
    end

    always_comb begin
        st_be = 4'hF;
        st_wd = in_store_data;
        case (in_op)
            OP_SB: begin
                st_be = 4'b0001 << in_result[1:0];
                st_wd = {4{in_store_data[7:0]}};
            end
            OP_SH: begin
                st_be = in_result[1] ? 4'b1100 : 4'b0011;
                st_wd = {2{in_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_align (
        .op    (op_q),
        .addr  (lane_q),
        .rdata (dmem.rdata),
        .data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wen       <= 1'b0;
            wb_windex    <= '0;
            wb_wdata     <= '0;
            wb_exception <= TRAP_STALL;
            dmem.req     <= 1'b0;
            dmem.we      <= 1'b0;
            dmem.be      <= '0;
            dmem.addr    <= '0;
            dmem.wdata   <= '0;
            op_q         <= OP_NONE;
            lane_q       <= '0;
            widx_q       <= '0;
        end else if (state == S_IDLE) begin
            wb_wen       <= 1'b0;
            wb_exception <= EXC_NONE;
            if (!in_valid) begin
                wb_wen <= 1'b0;
            end else if (exception_in != EXC_NONE) begin
                wb_exception <= exception_in;
            end else if (mis) begin
                wb_exception <= ld ? EXC_ADEL : EXC_ADES;
            end else if (!(ld || st)) begin
                wb_wen    <= in_wen;
                wb_windex <= in_windex;
                wb_wdata  <= in_result;
            end else begin
                op_q       <= in_op;
                lane_q     <= in_result[1:0];
                widx_q     <= in_windex;
                dmem.req   <= 1'b1;
                dmem.we    <= st;
                dmem.addr  <= {in_result[31:2], 2'b00};
                dmem.be    <= st ? st_be : 4'hF;
                dmem.wdata <= st_wd;
            end
        end else begin
            wb_wen       <= 1'b0;
            wb_exception <= EXC_NONE;
            if (dmem.ack || tmo) begin
                dmem.req <= 1'b0;
                dmem.we  <= 1'b0;
            end
            if (dmem.ack && !dmem.err && is_load(op_q)) begin
                wb_wen    <= 1'b1;
                wb_windex <= widx_q;
                wb_wdata  <= ld_data;
            end else if ((dmem.ack && dmem.err) || tmo) begin
                wb_exception <= EXC_BUS;
            end
        end
    end

endmodule
